bsg_flow_credit_arbiter: RTL and testbench

BSG_FLOW_CREDIT_ARBITER -- requirements
Module: bsg_flow_credit_arbiter

---
 rtl/bsg_flow_credit_arbiter.sv | 111 +++++++++++
 tb/tb_bsg_flow_credit_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_flow_credit_arbiter.sv
// Round-robin arbiter sharing one credit-managed downstream buffer
// among several requesters, with per-requester outstanding caps.
module bsg_flow_credit_arbiter #(
  parameter int num_req_p = 4,
  parameter int els_p     = 256,
  parameter int max_out_p = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           v_i,
  output logic [num_req_p-1:0]           yumi_o,
  output logic                           v_o,
  output logic [$clog2(num_req_p)-1:0]   sel_id_o,
  input  logic                           credit_v_i,
  input  logic [$clog2(num_req_p)-1:0]   credit_id_i,
  output logic [$clog2(els_p+1)-1:0]     credit_count_o,
  output logic                           error_o
);

  localparam int id_w  = $clog2(num_req_p);
  localparam int cnt_w = $clog2(els_p+1);
  localparam int out_w = $clog2(max_out_p+1);

  logic [id_w-1:0]      last_grant;
  logic [cnt_w-1:0]     credit_count;
  logic [out_w-1:0]     outstanding [num_req_p];
  logic                 error;

  logic [num_req_p-1:0] eligible;
  logic [num_req_p-1:0] busy;
  logic [num_req_p-1:0] ret_hit;
  logic [num_req_p-1:0] grant;
  logic                 has_credit;
  logic                 has_room;
  logic                 found;
  logic                 ret_ok;
  logic                 ret_bad;
  logic [id_w-1:0]      pick;

  assign has_credit = (credit_count != '0);
  assign has_room   = (credit_count < cnt_w'(els_p));

  always_comb begin
    eligible = '0;
    busy     = '0;
    for (int i = 0; i < num_req_p; i++) begin
      busy[i]     = (outstanding[i] != '0);
      eligible[i] = v_i[i] & has_credit & ~reset_i
                  & (outstanding[i] < out_w'(max_out_p));
    end
  end

  // Grant path never looks at the return inputs.
  always_comb begin
    logic [id_w:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = {1'b0, last_grant} + (id_w+1)'(k);
      if (cand >= (id_w+1)'(num_req_p))
        cand = cand - (id_w+1)'(num_req_p);
      if (!found && eligible[cand[id_w-1:0]]) begin
        found = 1'b1;
        pick  = cand[id_w-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < num_req_p; i++)
      grant[i] = found & (pick == id_w'(i));
  end

  // Out-of-range ids match no requester and so fall into ret_bad.
  always_comb begin
    ret_hit = '0;
    for (int i = 0; i < num_req_p; i++)
      ret_hit[i] = credit_v_i & ~reset_i & (credit_id_i == id_w'(i));
  end

  assign ret_ok  = (|(ret_hit & busy)) & has_room;
  assign ret_bad = credit_v_i & ~reset_i & ~ret_ok;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_count <= cnt_w'(els_p);
      last_grant   <= id_w'(num_req_p-1);
      error        <= 1'b0;
      for (int i = 0; i < num_req_p; i++)
        outstanding[i] <= '0;
    end else begin
      if (found)
        last_grant <= pick;
      if (ret_bad)
        error <= 1'b1;
      credit_count <= credit_count - cnt_w'(found) + cnt_w'(ret_ok);
      for (int i = 0; i < num_req_p; i++)
        outstanding[i] <= outstanding[i] + out_w'(grant[i])
                        - out_w'(ret_hit[i] & ret_ok);
    end
  end

  assign yumi_o         = grant;
  assign v_o            = found;
  assign sel_id_o       = found ? pick : '0;
  assign credit_count_o = credit_count;
  assign error_o        = error;

endmodule

// File: tb/tb_bsg_flow_credit_arbiter.sv
// Randomized and directed checks of bsg_flow_credit_arbiter against
// a queue-free arithmetic model of the credit/outstanding rules.
module tb_bsg_flow_credit_arbiter;

  localparam int N   = 4;
  localparam int ELS = 256;
  localparam int MAX = 64;

  logic       clk;
  logic       reset_i;
  logic [3:0] v_i;
  logic [3:0] yumi_o;
  logic       v_o;
  logic [1:0] sel_id_o;
  logic       credit_v_i;
  logic [1:0] credit_id_i;
  logic [8:0] credit_count_o;
  logic       error_o;

  int errors = 0;
  int checks = 0;

  int m_cred;
  int m_last;
  int m_out [N];
  bit m_err;

  bsg_flow_credit_arbiter #(
    .num_req_p(N),
    .els_p(ELS),
    .max_out_p(MAX)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .v_i(v_i),
    .yumi_o(yumi_o),
    .v_o(v_o),
    .sel_id_o(sel_id_o),
    .credit_v_i(credit_v_i),
    .credit_id_i(credit_id_i),
    .credit_count_o(credit_count_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] v, input logic rst);
    int c;
    if (rst) return -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (v[c] && m_cred > 0 && m_out[c] < MAX) return c;
    end
    return -1;
  endfunction

  function automatic void model_update(input logic cv, input logic [1:0] cid,
                                       input logic rst, input int p);
    bit acc;
    if (rst) begin
      m_cred = ELS;
      m_last = N - 1;
      m_err  = 1'b0;
      for (int i = 0; i < N; i++) m_out[i] = 0;
      return;
    end
    acc = cv && (m_out[cid] > 0) && (m_cred < ELS);
    if (cv && !acc) m_err = 1'b1;
    if (p >= 0) begin
      m_cred--;
      m_out[p]++;
      m_last = p;
    end
    if (acc) begin
      m_cred++;
      m_out[cid]--;
    end
  endfunction

  task automatic cycle(input logic [3:0] v, input logic cv,
                       input logic [1:0] cid, input logic rst,
                       output logic [3:0] gy, output logic gv,
                       output logic [1:0] gs, output logic [3:0] ey,
                       output int ep);
    v_i         = v;
    credit_v_i  = cv;
    credit_id_i = cid;
    reset_i     = rst;
    #1;
    gy = yumi_o;
    gv = v_o;
    gs = sel_id_o;
    ep = model_pick(v, rst);
    ey = (ep < 0) ? 4'b0000 : 4'(1 << ep);
    @(posedge clk);
    model_update(cv, cid, rst, ep);
    @(negedge clk);
  endtask

  logic [3:0] gy, ey;
  logic       gv;
  logic [1:0] gs;
  int         ep;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b1, 2'(i), 1'b1, gy, gv, gs, ey, ep);
      checks++;
      if (gy !== 4'b0000 || gv !== 1'b0 || gs !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs yumi=%b v=%b sel=%0d want 0000/0/0", gy, gv, gs);
      end
    end
    checks++;
    if (credit_count_o !== 9'd256 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state cc=%0d err=%b want 256/0", credit_count_o, error_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
      want = 4'(1 << (i % 4));
      checks++;
      if (gy !== want || gy !== ey || gs !== 2'(i % 4) || gv !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d yumi=%b sel=%0d want %b/%0d", i, gy, gs, want, i % 4);
      end
    end
    checks++;
    if (credit_count_o !== 9'd248) begin
      errors++;
      $display("FAIL rr_credit cc=%0d want 248", credit_count_o);
    end
  endtask

  task automatic test_exhaust();
    int bad = 0;
    for (int i = 0; i < 248; i++) begin
      cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
      if (gy !== ey) bad++;
    end
    checks++;
    if (bad != 0 || credit_count_o !== 9'd0) begin
      errors++;
      $display("FAIL exhaust_fill mism=%0d cc=%0d want 0/0", bad, credit_count_o);
    end
    cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0000 || gv !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_nogrant yumi=%b want 0000", gy);
    end
    cycle(4'b1111, 1'b1, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0000) begin
      errors++;
      $display("FAIL exhaust_sameret yumi=%b want 0000", gy);
    end
    cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0001 || gs !== 2'd0 || credit_count_o !== 9'd0) begin
      errors++;
      $display("FAIL exhaust_regrant yumi=%b cc=%0d want 0001/0", gy, credit_count_o);
    end
    cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0000 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_after yumi=%b err=%b want 0000/0", gy, error_o);
    end
  endtask

  task automatic test_cap();
    int bad = 0;
    cycle(4'b0000, 1'b0, 2'd0, 1'b1, gy, gv, gs, ey, ep);
    for (int i = 0; i < MAX; i++) begin
      cycle(4'b0001, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
      if (gy !== 4'b0001) bad++;
    end
    cycle(4'b0001, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (bad != 0 || gy !== 4'b0000 || credit_count_o !== 9'd192) begin
      errors++;
      $display("FAIL cap_fill mism=%0d yumi=%b cc=%0d want 0/0000/192", bad, gy, credit_count_o);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0011, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
      checks++;
      if (gy !== 4'b0010 || gs !== 2'd1) begin
        errors++;
        $display("FAIL cap_skip%0d yumi=%b want 0010", i, gy);
      end
    end
    cycle(4'b0011, 1'b1, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0010) begin
      errors++;
      $display("FAIL cap_retcycle yumi=%b want 0010", gy);
    end
    cycle(4'b0011, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0001 || gy !== ey) begin
      errors++;
      $display("FAIL cap_release yumi=%b want 0001", gy);
    end
    cycle(4'b0011, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0010) begin
      errors++;
      $display("FAIL cap_recap yumi=%b want 0010", gy);
    end
  endtask

  task automatic test_simultaneous();
    cycle(4'b0000, 1'b0, 2'd0, 1'b1, gy, gv, gs, ey, ep);
    cycle(4'b0010, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    cycle(4'b0010, 1'b1, 2'd1, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0010 || credit_count_o !== 9'd255 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL simul yumi=%b cc=%0d err=%b want 0010/255/0", gy, credit_count_o, error_o);
    end
    cycle(4'b0000, 1'b1, 2'd1, 1'b0, gy, gv, gs, ey, ep);
    cycle(4'b0000, 1'b1, 2'd1, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (credit_count_o !== 9'd256 || error_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_outcount cc=%0d err=%b want 256/1", credit_count_o, error_o);
    end
  endtask

  task automatic test_errors();
    cycle(4'b0000, 1'b0, 2'd0, 1'b1, gy, gv, gs, ey, ep);
    cycle(4'b0000, 1'b1, 2'd2, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (credit_count_o !== 9'd256 || error_o !== 1'b1) begin
      errors++;
      $display("FAIL err_full cc=%0d err=%b want 256/1", credit_count_o, error_o);
    end
    cycle(4'b0000, 1'b0, 2'd0, 1'b1, gy, gv, gs, ey, ep);
    cycle(4'b0001, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    cycle(4'b0000, 1'b1, 2'd3, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (credit_count_o !== 9'd255 || error_o !== 1'b1) begin
      errors++;
      $display("FAIL err_zero_out cc=%0d err=%b want 255/1", credit_count_o, error_o);
    end
    for (int i = 0; i < 6; i++)
      cycle(4'($urandom), 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (error_o !== 1'b1 || credit_count_o !== 9'(m_cred)) begin
      errors++;
      $display("FAIL err_sticky err=%b cc=%0d want 1/%0d", error_o, credit_count_o, m_cred);
    end
  endtask

  task automatic test_reset_mid();
    cycle(4'b0000, 1'b0, 2'd0, 1'b1, gy, gv, gs, ey, ep);
    for (int i = 0; i < 10; i++)
      cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (credit_count_o !== 9'd246) begin
      errors++;
      $display("FAIL mid_pre cc=%0d want 246", credit_count_o);
    end
    cycle(4'b1111, 1'b1, 2'd1, 1'b1, gy, gv, gs, ey, ep);
    checks++;
    if (credit_count_o !== 9'd256 || error_o !== 1'b0 || gy !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset cc=%0d err=%b yumi=%b want 256/0/0000", credit_count_o, error_o, gy);
    end
    cycle(4'b1111, 1'b0, 2'd0, 1'b0, gy, gv, gs, ey, ep);
    checks++;
    if (gy !== 4'b0001 || gs !== 2'd0) begin
      errors++;
      $display("FAIL mid_first yumi=%b want 0001", gy);
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    logic       cv, rst;
    logic [1:0] cid;
    int         s;
    for (int i = 0; i < 3000; i++) begin
      v   = 4'($urandom);
      cv  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      s   = $urandom_range(0, N - 1);
      cid = 2'(s);
      if ($urandom_range(0, 9) != 0)
        for (int k = 0; k < N; k++)
          if (m_out[(s + k) % N] > 0) begin
            cid = 2'((s + k) % N);
            break;
          end
      cycle(v, cv, cid, rst, gy, gv, gs, ey, ep);
      checks++;
      if (gy !== ey || gv !== (ep >= 0) || gs !== 2'((ep < 0) ? 0 : ep)) begin
        errors++;
        $display("FAIL rand_grant c%0d yumi=%b v=%b sel=%0d want %b", i, gy, gv, gs, ey);
      end
      checks++;
      if (credit_count_o !== 9'(m_cred) || error_o !== m_err) begin
        errors++;
        $display("FAIL rand_state c%0d cc=%0d err=%b want %0d/%b", i, credit_count_o, error_o, m_cred, m_err);
      end
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    v_i         = '0;
    credit_v_i  = 1'b0;
    credit_id_i = '0;
    m_cred      = ELS;
    m_last      = N - 1;
    m_err       = 1'b0;
    for (int i = 0; i < N; i++) m_out[i] = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_exhaust();
    test_cap();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
